game_ctrl: RTL and testbench

Turn-based two-player rhythm game controller. Conditions the two player buttons and runs the QI/QGAME_1/QGAME_2/QDONE state machine. Advances the falling-note position on a slow tick and keeps both scores. Its outputs directly drive the VGA note renderer (`position`) and the LED/SSD status stage (`state`, `p1_score`, `p2_score`).

---
 rtl/game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_game_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Two-player rhythm game controller: button conditioning, turn FSM, note position and scores.
// Define GAME_CTRL_DEBOUNCE_EN to compile in the per-button debounce counters.
module game_ctrl #(
  parameter int POS_TOP   = 140,
  parameter int POS_BOT   = 380,
  parameter int HIT_LO    = 320,
  parameter int HIT_HI    = 360,
  parameter int WIN_SCORE = 10,
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic       btn_p1,
  input  logic       btn_p2,
  output logic [1:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [9:0] position,
  output logic       hit,
  output logic       miss
);

  localparam logic [1:0] QI      = 2'b00;
  localparam logic [1:0] QGAME_1 = 2'b01;
  localparam logic [1:0] QGAME_2 = 2'b10;
  localparam logic [1:0] QDONE   = 2'b11;

  localparam logic [9:0] TOP     = 10'(POS_TOP);
  localparam logic [9:0] BOT     = 10'(POS_BOT);
  localparam logic [9:0] LO      = 10'(HIT_LO);
  localparam logic [9:0] HI      = 10'(HIT_HI);
  localparam logic [9:0] POS_ONE = 10'd1;
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [3:0] SC_ONE  = 4'd1;

  // Bit 0 is player 1, bit 1 is player 2 throughout the conditioning path.
  logic [1:0] btn;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] press;

  assign btn = {btn_p2, btn_p1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [DB_W-1:0] db_cnt [2];

  // Any return of the synchronized level to the debounced level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      level     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end
`else
  assign level = sync_b;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= '0;
      press   <= '0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  logic       active_press;
  logic       in_window;
  logic [3:0] active_score;
  logic [1:0] other_player;

  always_comb begin
    active_press = 1'b0;
    if (state == QGAME_1) begin
      active_press = press[0];
    end else if (state == QGAME_2) begin
      active_press = press[1];
    end
  end

  assign in_window    = (position >= LO) && (position <= HI);
  assign active_score = (state == QGAME_2) ? p2_score : p1_score;
  assign other_player = (state == QGAME_1) ? QGAME_2 : QGAME_1;

  // A press outranks a same-cycle tick, and the outcome uses the pre-tick position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= QI;
      p1_score <= '0;
      p2_score <= '0;
      position <= TOP;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (!start) begin
        state    <= QI;
        position <= TOP;
      end else begin
        case (state)
          QI: begin
            state    <= QGAME_1;
            position <= TOP;
            p1_score <= '0;
            p2_score <= '0;
          end
          QGAME_1, QGAME_2: begin
            if (active_press) begin
              position <= TOP;
              if (in_window) begin
                hit <= 1'b1;
                if (state == QGAME_1) begin
                  p1_score <= p1_score + SC_ONE;
                end else begin
                  p2_score <= p2_score + SC_ONE;
                end
                state <= ((active_score + SC_ONE) == WIN) ? QDONE : other_player;
              end else begin
                miss  <= 1'b1;
                state <= other_player;
              end
            end else if (tick) begin
              if (position >= BOT) begin
                miss     <= 1'b1;
                position <= TOP;
                state    <= other_player;
              end else begin
                position <= position + POS_ONE;
              end
            end
          end
          default: begin
            state <= QDONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with small geometry (rows 0..20, window 10..12, win at 3).
// Expectations adapt to whether GAME_CTRL_DEBOUNCE_EN is defined.
module tb_game_ctrl;

  localparam int DB = 4;
`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       tick;
  logic       btn_p1;
  logic       btn_p2;
  logic [1:0] state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [9:0] position;
  logic       hit;
  logic       miss;

  int vectors     = 0;
  int miscompares = 0;
  int hit_seen    = 0;
  int miss_seen   = 0;
  int hit_base;
  int miss_base;

  game_ctrl #(
    .POS_TOP(0), .POS_BOT(20), .HIT_LO(10), .HIT_HI(12),
    .WIN_SCORE(3), .DB_CYCLES(DB), .DB_W(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
    .btn_p1(btn_p1), .btn_p2(btn_p2), .state(state),
    .p1_score(p1_score), .p2_score(p2_score), .position(position),
    .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  // Pulse counters sample the pre-edge value, so each visible pulse is counted once.
  always @(posedge clk) begin
    if (hit) hit_seen++;
    if (miss) miss_seen++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int st, input int s1, input int s2, input int pos);
    checkOutput({tag, " state"}, int'(state), st);
    checkOutput({tag, " p1_score"}, int'(p1_score), s1);
    checkOutput({tag, " p2_score"}, int'(p2_score), s2);
    checkOutput({tag, " position"}, int'(position), pos);
  endtask

  task automatic checkPulses(input string tag, input int h, input int m);
    checkOutput({tag, " hit"}, int'(hit), h);
    checkOutput({tag, " miss"}, int'(miss), m);
  endtask

  task automatic applyStimulus(input logic b1, input logic b2, input logic tk, input int cycles);
    btn_p1 = b1;
    btn_p2 = b2;
    tick   = tk;
    repeat (cycles) @(negedge clk);
    tick = 1'b0;
  endtask

  // Returns on the cycle where the resulting hit/miss is visible.
  task automatic pressButton(input int player);
    applyStimulus(player == 1, player == 2, 1'b0, LAT + 1);
  endtask

  task automatic releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b0, LAT + 2);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    btn_p1  = 1'b0;
    btn_p2  = 1'b0;
    repeat (3) @(negedge clk);
    checkState("reset", 0, 0, 0, 0);
    checkPulses("reset", 0, 0);

    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("idle", 0, 0, 0, 0);
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("start", 1, 0, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 11);
    checkState("ticks11", 1, 0, 0, 11);
    applyStimulus(1'b1, 1'b0, 1'b0, LAT);
    checkPulses("p1 before latency", 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkPulses("p1 hit", 1, 0);
    checkState("p1 hit", 2, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkPulses("p1 hit held", 0, 0);
    releaseButtons();

    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    checkState("p2 ticks5", 2, 1, 0, 5);
    pressButton(2);
    checkPulses("p2 early", 0, 1);
    checkState("p2 early", 1, 1, 0, 0);
    releaseButtons();
    checkPulses("p2 early after", 0, 0);

    pressButton(2);
    checkPulses("p2 inactive", 0, 0);
    checkState("p2 inactive", 1, 1, 0, 0);
    releaseButtons();

    applyStimulus(1'b0, 1'b0, 1'b1, 20);
    checkState("bottom", 1, 1, 0, 20);
    checkPulses("bottom", 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkPulses("bottom tick", 0, 1);
    checkState("bottom tick", 2, 1, 0, 0);

    pressButton(2);
    checkPulses("p2 miss", 0, 1);
    checkState("p2 miss", 1, 1, 0, 0);
    releaseButtons();

    applyStimulus(1'b0, 1'b0, 1'b1, 11);
    hit_base  = hit_seen;
    miss_base = miss_seen;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(s % 2 == 0, 1'b0, 1'b0, 2);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, LAT + 3);
    releaseButtons();
    checkOutput("bounce hits", hit_seen - hit_base, 1);
    checkOutput("bounce misses", miss_seen - miss_base, 0);
    checkState("bounce", 2, 2, 0, 0);

    miss_base = miss_seen;
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, LAT + 4);
`ifdef GAME_CTRL_DEBOUNCE_EN
    checkOutput("short press misses", miss_seen - miss_base, 0);
    checkOutput("short press state", int'(state), 2);
`else
    checkOutput("short press misses", miss_seen - miss_base, 1);
    checkOutput("short press state", int'(state), 1);
`endif

    start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("stop", 0, 2, 0, 0);
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("restart", 1, 0, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 10);
    pressButton(1);
    checkPulses("win lo edge", 1, 0);
    checkState("win lo edge", 2, 1, 0, 0);
    releaseButtons();
    pressButton(2);
    checkState("win p2a", 1, 1, 0, 0);
    releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b1, 12);
    pressButton(1);
    checkPulses("win hi edge", 1, 0);
    checkState("win hi edge", 2, 2, 0, 0);
    releaseButtons();
    pressButton(2);
    checkState("win p2b", 1, 2, 0, 0);
    releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b1, 13);
    pressButton(1);
    checkPulses("past window", 0, 1);
    checkState("past window", 2, 2, 0, 0);
    releaseButtons();
    pressButton(2);
    checkState("win p2c", 1, 2, 0, 0);
    releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b1, 11);
    pressButton(1);
    checkPulses("winning hit", 1, 0);
    checkState("winning hit", 3, 3, 0, 0);
    releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkState("done hold", 3, 3, 0, 0);
    pressButton(1);
    checkPulses("done press", 0, 0);
    checkState("done press", 3, 3, 0, 0);
    releaseButtons();

    start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("done stop", 0, 3, 0, 0);
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("done restart", 1, 0, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 11);
    pressButton(1);
    checkState("pre reset hit", 2, 1, 0, 0);
    releaseButtons();
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    checkState("pre reset", 2, 1, 0, 5);
    reset_n = 1'b0;
    #2;
    checkState("async reset", 0, 0, 0, 0);
    checkPulses("async reset", 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
